// File: rtl/sdram_wr_buffer_pkg.sv
// Shared SDRAM write-buffer definitions: FSM state encoding and default depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdram_wr_buffer_pkg;

    // Default buffer depth is 2**SDRAM_WR_DEPTH_LOG2 entries.
    localparam int unsigned SDRAM_WR_DEPTH_LOG2 = 2;

    // Saturation value of the optional drop counter.
    localparam logic [15:0] SDRAM_WR_DROP_MAX = 16'hFFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Storage and pointers for the SDRAM write buffer; head entry always visible.
// Latency: a push is visible at the head one cycle later; full/empty are registered.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports: clk/rst_n; push_i + push_dat_i write an entry; pop_i retires the head;
//        head_dat_o is the oldest entry; full_o / empty_o are registered flags.
module sdram_wr_fifo
    import sdram_wr_buffer_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH_LOG2 = SDRAM_WR_DEPTH_LOG2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    // One extra pointer bit distinguishes full (MSBs differ) from empty (equal).
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push_i};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop_i};
        // Flags are computed from the next pointers so they can be registered
        // without lagging the pointers by a cycle.
        full_d   = (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]) &&
                   (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Data array carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule

// File: rtl/sdram_wr_buffer.sv
// Buffers write-mux words and issues them one at a time as SDRAM write requests.
// Latency: 2 cycles from a push into an empty buffer to sdram_req; <= 1 word per 2 cycles.
// Backpressure: writes arriving while full are dropped and flagged in sticky overflow.
//
// Ports: clk, rst_n (async, active-low); wr_en_sdram/wr_data_sdram/wr_address in;
//        full, overflow status; sdram_req/sdram_addr/sdram_data held until sdram_ack.
//        Optional drop_count (16-bit, saturating) when SDRAM_WR_BUF_STATS_EN is defined.
module sdram_wr_buffer
    import sdram_wr_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = SDRAM_WR_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_sdram,
    input  logic [DATA_WIDTH-1:0] wr_data_sdram,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    output logic                  full,
    output logic                  overflow,
    output logic                  sdram_req,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0] sdram_data,
    input  logic                  sdram_ack
`ifdef SDRAM_WR_BUF_STATS_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overflow_q, overflow_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head_dat;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // A full buffer drops the write even if the head retires this cycle.
    assign push = wr_en_sdram && !fifo_full;
    assign drop = wr_en_sdram &&  fifo_full;
    // Ack only counts while a request is outstanding.
    assign pop  = (state_q == ST_REQ) && sdram_ack;

    sdram_wr_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i ({wr_address, wr_data_sdram}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        overflow_d = overflow_q | drop;
        case (state_q)
            ST_IDLE: begin
                // Latch the head on entry to REQ so addr/data stay stable until ack.
                if (!fifo_empty) begin
                    state_d = ST_REQ;
                    addr_d  = head_dat[ENTRY_W-1:DATA_WIDTH];
                    data_d  = head_dat[DATA_WIDTH-1:0];
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    assign full       = fifo_full;
    assign overflow   = overflow_q;
    assign sdram_req  = (state_q == ST_REQ);
    assign sdram_addr = addr_q;
    assign sdram_data = data_q;

`ifdef SDRAM_WR_BUF_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != SDRAM_WR_DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_wr_buffer.sv
// Directed self-checking bench for sdram_wr_buffer.
// Latency: n/a.
// Backpressure: the bench plays the SDRAM controller via sdram_ack.
module tb_sdram_wr_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en_sdram;
    logic [31:0] wr_data_sdram;
    logic [31:0] wr_address;
    logic        full;
    logic        overflow;
    logic        sdram_req;
    logic [31:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_ack;
`ifdef SDRAM_WR_BUF_STATS_EN
    logic [15:0] drop_count;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int nw;
    int nr;
    bit seen;

    always #5 clk = ~clk;

    sdram_wr_buffer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_sdram   (wr_en_sdram),
        .wr_data_sdram (wr_data_sdram),
        .wr_address    (wr_address),
        .full          (full),
        .overflow      (overflow),
        .sdram_req     (sdram_req),
        .sdram_addr    (sdram_addr),
        .sdram_data    (sdram_data),
        .sdram_ack     (sdram_ack)
`ifdef SDRAM_WR_BUF_STATS_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en_sdram = 1'b0;
        sdram_ack   = 1'b0;
        rst_n       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        wr_en_sdram   = 1'b1;
        wr_address    = a;
        wr_data_sdram = d;
        tick();
        wr_en_sdram = 1'b0;
    endtask

    // Waits (bounded) for a request, checks the entry, acks it for one cycle.
    task automatic ack_word(input string tag, input logic [31:0] a, input logic [31:0] d);
        int k;
        k = 0;
        while (!sdram_req && k < 20) begin
            tick();
            k++;
        end
        check_val({tag, "_req"}, {63'd0, sdram_req}, 64'd1);
        check_val({tag, "_entry"}, {sdram_addr, sdram_data}, {a, d});
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check_val({tag, "_req_drop"}, {63'd0, sdram_req}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        wr_en_sdram   = 1'b0;
        sdram_ack     = 1'b0;
        wr_data_sdram = '0;
        wr_address    = '0;

        // Reset is asynchronous: outputs are cleared before any clock edge.
        #3;
        check_val("rst_full", {63'd0, full}, 64'd0);
        check_val("rst_ovf",  {63'd0, overflow}, 64'd0);
        check_val("rst_req",  {63'd0, sdram_req}, 64'd0);
        check_val("rst_addr_data", {sdram_addr, sdram_data}, 64'd0);
`ifdef SDRAM_WR_BUF_STATS_EN
        check_val("rst_drop_cnt", {48'd0, drop_count}, 64'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Single write into an empty buffer: request two cycles later.
        push_word(32'h0000_0010, 32'hDEAD_BEEF);
        check_val("t1_req_early", {63'd0, sdram_req}, 64'd0);
        tick();
        check_val("t1_req", {63'd0, sdram_req}, 64'd1);
        check_val("t1_entry", {sdram_addr, sdram_data}, 64'h0000_0010_DEAD_BEEF);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check_val("t1_req_after_ack", {63'd0, sdram_req}, 64'd0);
        tick();
        tick();
        check_val("t1_idle_empty", {63'd0, sdram_req}, 64'd0);

        // Ack while idle must not pop anything.
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        check_val("t1_idle_ack", {63'd0, sdram_req}, 64'd0);
        push_word(32'h0000_0020, 32'h1111_1111);
        ack_word("t1_after_idle_ack", 32'h0000_0020, 32'h1111_1111);
        tick();
        tick();
        check_val("t1_no_ghost", {63'd0, sdram_req}, 64'd0);

        // Fill to full, then one dropped write; drain in order.
        do_reset();
        wr_en_sdram = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_address    = 32'h0000_1000 + 32'(i);
            wr_data_sdram = 32'(i + 1);
            tick();
        end
        wr_en_sdram = 1'b0;
        check_val("t2_full", {63'd0, full}, 64'd1);
        check_val("t2_no_ovf_yet", {63'd0, overflow}, 64'd0);
        push_word(32'h0000_1004, 32'd5);
        check_val("t2_ovf", {63'd0, overflow}, 64'd1);
        check_val("t2_still_full", {63'd0, full}, 64'd1);
        ack_word("t2_w1", 32'h0000_1000, 32'd1);
        check_val("t2_not_full", {63'd0, full}, 64'd0);
        ack_word("t2_w2", 32'h0000_1001, 32'd2);
        ack_word("t2_w3", 32'h0000_1002, 32'd3);
        ack_word("t2_w4", 32'h0000_1003, 32'd4);
        repeat (4) tick();
        check_val("t2_drained", {63'd0, sdram_req}, 64'd0);
        check_val("t2_ovf_sticky", {63'd0, overflow}, 64'd1);

        // Full buffer: push and ack in the same cycle -> push dropped, 3 left.
        do_reset();
        wr_en_sdram = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_address    = 32'h0000_3000 + 32'(i);
            wr_data_sdram = 32'h30 + 32'(i);
            tick();
        end
        check_val("t3_req", {63'd0, sdram_req}, 64'd1);
        wr_address    = 32'h0000_3FFF;
        wr_data_sdram = 32'h0000_0BAD;
        sdram_ack     = 1'b1;
        tick();
        wr_en_sdram = 1'b0;
        sdram_ack   = 1'b0;
        check_val("t3_ovf", {63'd0, overflow}, 64'd1);
        check_val("t3_full", {63'd0, full}, 64'd0);
        ack_word("t3_w2", 32'h0000_3001, 32'h31);
        ack_word("t3_w3", 32'h0000_3002, 32'h32);
        ack_word("t3_w4", 32'h0000_3003, 32'h33);
        repeat (5) tick();
        check_val("t3_only_three", {63'd0, sdram_req}, 64'd0);

        // Ten writes, controller acks one cycle after the request: pointers wrap.
        do_reset();
        nw   = 0;
        nr   = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (sdram_ack) begin
                sdram_ack = 1'b0;
            end else if (sdram_req && seen) begin
                check_val("t4_word", {sdram_addr, sdram_data},
                          {32'h0000_0100 + 32'(nr * 4), 32'hA000_0000 + 32'(nr)});
                nr++;
                sdram_ack = 1'b1;
                seen      = 1'b0;
            end else if (sdram_req) begin
                seen = 1'b1;
            end
            if ((cyc % 4 == 0) && nw < 10) begin
                wr_en_sdram   = 1'b1;
                wr_address    = 32'h0000_0100 + 32'(nw * 4);
                wr_data_sdram = 32'hA000_0000 + 32'(nw);
                nw++;
            end else begin
                wr_en_sdram = 1'b0;
            end
            tick();
        end
        wr_en_sdram = 1'b0;
        sdram_ack   = 1'b0;
        check_val("t4_count", 64'(nr), 64'd10);
        check_val("t4_no_ovf", {63'd0, overflow}, 64'd0);

        // Reset while a request is outstanding with three entries buffered.
        do_reset();
        wr_en_sdram = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_address    = 32'h0000_5000 + 32'(i);
            wr_data_sdram = 32'h5A + 32'(i);
            tick();
        end
        wr_en_sdram = 1'b0;
        check_val("t5_req_before", {63'd0, sdram_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("t5_req_async", {63'd0, sdram_req}, 64'd0);
        check_val("t5_addr_data", {sdram_addr, sdram_data}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check_val("t5_no_req", {63'd0, sdram_req}, 64'd0);
        push_word(32'h0000_0077, 32'h1234_5678);
        check_val("t5_new_early", {63'd0, sdram_req}, 64'd0);
        tick();
        check_val("t5_new_req", {63'd0, sdram_req}, 64'd1);
        check_val("t5_new_entry", {sdram_addr, sdram_data}, 64'h0000_0077_1234_5678);

`ifdef SDRAM_WR_BUF_STATS_EN
        // Three dropped writes are counted.
        do_reset();
        wr_en_sdram = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_address    = 32'h0000_6000 + 32'(i);
            wr_data_sdram = 32'(i);
            tick();
        end
        wr_en_sdram = 1'b0;
        check_val("t6_drop_cnt", {48'd0, drop_count}, 64'd3);
        check_val("t6_ovf", {63'd0, overflow}, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_wr_buffer.md
SDRAM_WR_BUFFER -- requirements
Module: sdram_wr_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 2, FIFO depth = 2**DEPTH_LOG2 entries.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en_sdram  input  1  write strobe from the write mux, one word per cycle.
REQ-007 SHALL have port wr_data_sdram  input  DATA_WIDTH  write data from the write mux.
REQ-008 SHALL have port wr_address  input  ADDR_WIDTH  write address, sampled with wr_en_sdram.
REQ-009 SHALL have port full  output  1  buffer full, registered.
REQ-010 SHALL have port overflow  output  1  sticky flag, a write was dropped.
REQ-011 SHALL have port sdram_req  output  1  write request to SDRAM controller.
REQ-012 SHALL have port sdram_addr  output  ADDR_WIDTH  request address.
REQ-013 SHALL have port sdram_data  output  DATA_WIDTH  request data.
REQ-014 SHALL have port sdram_ack  input  1  controller accepted current request, single-cycle pulse.

Function
REQ-015 SHALL push {wr_address, wr_data_sdram} on a rising clk when wr_en_sdram=1 and full=0.
REQ-016 SHALL drop the write and set overflow=1 when wr_en_sdram=1 and full=1, even if a pop occurs in the same cycle.
REQ-017 SHALL keep overflow set until reset.
REQ-018 SHALL use read/write pointers of DEPTH_LOG2+1 bits; wrap-around is modulo 2**DEPTH_LOG2; full when MSBs differ and the remaining bits match; empty when pointers are equal.
REQ-019 SHALL implement FSM IDLE/REQ: IDLE->REQ when not empty; REQ->IDLE on sdram_ack, popping the head entry that cycle.
REQ-020 SHALL drive sdram_req=1 only in REQ, with sdram_addr/sdram_data equal to the head entry and stable until ack.
REQ-021 SHALL ignore sdram_ack while in IDLE.
REQ-022 SHALL give a latency of 2 cycles from push into an empty buffer to sdram_req=1, with no bypass path.
REQ-023 SHALL allow a simultaneous push and pop when not full; occupancy is unchanged.
REQ-024 SHALL sustain at most one drained word per 2 cycles (REQ, ack, IDLE, REQ).

Reset
REQ-025 SHALL on rst_n=0 immediately clear the pointers, full=0, overflow=0, sdram_req=0, sdram_addr=0, sdram_data=0 and state=IDLE.
REQ-026 SHALL discard all buffered entries on reset mid-operation, including an unacknowledged request.

Configuration
REQ-027 SHALL when SDRAM_WR_BUF_STATS_EN is defined add output drop_count (16 bits), incremented per dropped write, saturating at 16'hFFFF and cleared by reset.
REQ-028 SHALL without SDRAM_WR_BUF_STATS_EN have no drop_count port or logic.

Structure
REQ-029 SHALL take FSM state encodings and the default depth constant from the shared SDRAM definitions include file.
REQ-030 SHALL place storage and pointers in sub-module sdram_wr_fifo; the FSM and handshake live in the top module.

Verification
REQ-031 SHALL cover: single write addr 0x00000010, data 0xDEADBEEF into an empty buffer -> sdram_req rises 2 cycles later with that addr/data; ack -> req=0 the next cycle.
REQ-032 SHALL cover: 4 writes with ack held low (DEPTH_LOG2=2) -> full=1; a 5th write -> overflow=1 and entries 1-4 drained in order.
REQ-033 SHALL cover: full buffer with a push and ack in the same cycle -> push dropped, overflow=1, occupancy 3.
REQ-034 SHALL cover: 10 writes with ack returned after 1 cycle -> pointers wrap, output order matches input order, no overflow.
REQ-035 SHALL cover: rst_n low while sdram_req=1 with 3 entries buffered -> req=0 immediately, no request after release until a new write.
REQ-036 SHALL cover: with SDRAM_WR_BUF_STATS_EN defined, 3 dropped writes -> drop_count=3.
